// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS main controller.
// Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB and drives the
// shared-ALU, single-memory datapath. FETCH and MEM stretch on mem_ready; a
// wait-cycle watchdog (MEM_TIMEOUT, 0 = off) halts the machine with a sticky
// bus_err when memory never answers.
//
// Optional feature (macro MULTICYCLE_ILLEGAL_TRAP_EN): an unknown
// opcode/funct in EXEC pulses illegal_o for one cycle and halts. Without the
// macro the port is absent and unknown instructions run as a 3-cycle NOP.
//
// Ports:
//   clk, reset        rising-edge clock, synchronous active-low reset
//   OpCode, Funct     IR[31:26] / IR[5:0]
//   mem_ready         memory completes the current access this cycle
//   PCWrite .. PCSource  datapath mux selects and enables
//   bus_err           sticky watchdog error
//   state_o           current state (debug)
//   illegal_o         illegal-instruction pulse (trap build only)
module multicycle_controller #(
  parameter int unsigned MEM_TIMEOUT = 15,
  parameter int unsigned TCNT_W      = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] OpCode,
  input  logic [5:0] Funct,
  input  logic       mem_ready,
  output logic       PCWrite,
  output logic       PCWriteCond,
  output logic [2:0] Branch,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] MemtoReg,
  output logic [1:0] RegDst,
  output logic       RegWrite,
  output logic       ExtOp,
  output logic       LuiOp,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [3:0] ALUOp,
  output logic [1:0] PCSource,
  output logic       bus_err,
  output logic [2:0] state_o
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  ,
  output logic       illegal_o
`endif
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd5
  } state_e;

  typedef enum logic [3:0] {
    ClsRalu, ClsRshift, ClsIalu, ClsLoad, ClsStore, ClsBranch,
    ClsJ, ClsJal, ClsJr, ClsJalr, ClsIllegal
  } cls_e;

  // Last wait cycle index before the watchdog fires (counter counts prior waits).
  localparam int unsigned      LastWaitInt = (MEM_TIMEOUT == 0) ? 0 : MEM_TIMEOUT - 1;
  localparam logic [TCNT_W-1:0] LastWait   = TCNT_W'(LastWaitInt);

  state_e            state_q, state_d;
  logic [TCNT_W-1:0] wcnt_q, wcnt_d;
  logic              bus_err_q, bus_err_d;
  cls_e              cls;
  logic              waiting;
  logic              timeout;

  // Instruction class from the IR fields.
  always_comb begin
    cls = ClsIllegal;
    case (OpCode)
      6'h00: begin
        case (Funct)
          6'h20, 6'h21, 6'h22, 6'h23, 6'h24,
          6'h25, 6'h26, 6'h27, 6'h2a, 6'h2b: cls = ClsRalu;
          6'h00, 6'h02, 6'h03:               cls = ClsRshift;
          6'h08:                             cls = ClsJr;
          6'h09:                             cls = ClsJalr;
          default:                           cls = ClsIllegal;
        endcase
      end
      6'h08, 6'h09, 6'h0a, 6'h0b, 6'h0c, 6'h0f: cls = ClsIalu;
      6'h23:                                    cls = ClsLoad;
      6'h2b:                                    cls = ClsStore;
      6'h01, 6'h04, 6'h05, 6'h06, 6'h07:        cls = ClsBranch;
      6'h02:                                    cls = ClsJ;
      6'h03:                                    cls = ClsJal;
      default:                                  cls = ClsIllegal;
    endcase
  end

  assign waiting = ((state_q == StFetch) || (state_q == StMem)) && !mem_ready;
  assign timeout = (MEM_TIMEOUT != 0) && waiting && (wcnt_q >= LastWait);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (mem_ready)    state_d = StDecode;
        else if (timeout) state_d = StHalt;
      end
      StDecode: state_d = StExec;
      StExec: begin
        case (cls)
          ClsRalu, ClsRshift, ClsIalu: state_d = StWb;
          ClsLoad, ClsStore:           state_d = StMem;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
          ClsIllegal:                  state_d = StHalt;
`endif
          default:                     state_d = StFetch;
        endcase
      end
      StMem: begin
        if (mem_ready)    state_d = (cls == ClsLoad) ? StWb : StFetch;
        else if (timeout) state_d = StHalt;
      end
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Wait counter: counts stalled cycles within one state, saturating.
  always_comb begin
    wcnt_d = wcnt_q;
    if (state_d != state_q)           wcnt_d = '0;
    else if (waiting && wcnt_q != '1) wcnt_d = wcnt_q + TCNT_W'(1);
  end

  assign bus_err_d = bus_err_q | timeout;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= StFetch;
      wcnt_q    <= '0;
      bus_err_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      wcnt_q    <= wcnt_d;
      bus_err_q <= bus_err_d;
    end
  end

  // Control outputs.
  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    Branch      = 3'b000;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    IRWrite     = 1'b0;
    MemtoReg    = 2'b00;
    RegDst      = 2'b00;
    RegWrite    = 1'b0;
    ExtOp       = 1'b0;
    LuiOp       = 1'b0;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    ALUOp       = 4'b0000;
    PCSource    = 2'b00;
    case (state_q)
      StFetch: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        IRWrite = mem_ready;
        PCWrite = mem_ready;
      end
      StDecode: begin
        // Precompute the branch target into ALUOut.
        ALUSrcB = 2'b11;
        ExtOp   = 1'b1;
      end
      StExec: begin
        ALUOp[3] = OpCode[0];
        if (OpCode == 6'h00)                         ALUOp[2:0] = 3'b010;
        else if (cls == ClsBranch)                   ALUOp[2:0] = 3'b001;
        else if (OpCode == 6'h0c)                    ALUOp[2:0] = 3'b100;
        else if (OpCode == 6'h0a || OpCode == 6'h0b) ALUOp[2:0] = 3'b101;
        case (cls)
          ClsRalu: ALUSrcA = 2'b01;
          ClsRshift: ALUSrcA = 2'b10;
          ClsIalu: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            ExtOp   = 1'b1;
            LuiOp   = (OpCode == 6'h0f);
          end
          ClsLoad, ClsStore: begin
            ALUSrcA = 2'b01;
            ALUSrcB = 2'b10;
            ExtOp   = 1'b1;
          end
          ClsBranch: begin
            ALUSrcA     = 2'b01;
            Branch      = OpCode[2:0];
            PCWriteCond = 1'b1;
            PCSource    = 2'b01;
          end
          ClsJ, ClsJal: begin
            PCWrite  = 1'b1;
            PCSource = 2'b10;
            if (cls == ClsJal) begin
              RegWrite = 1'b1;
              RegDst   = 2'b10;
              MemtoReg = 2'b10;
            end
          end
          ClsJr, ClsJalr: begin
            PCWrite  = 1'b1;
            PCSource = 2'b11;
            if (cls == ClsJalr) begin
              RegWrite = 1'b1;
              RegDst   = 2'b01;
              MemtoReg = 2'b10;
            end
          end
          default: ;
        endcase
      end
      StMem: begin
        IorD     = 1'b1;
        MemRead  = (cls == ClsLoad);
        MemWrite = (cls == ClsStore);
      end
      StWb: begin
        RegWrite = 1'b1;
        case (cls)
          ClsIalu: MemtoReg = 2'b01;
          ClsRalu, ClsRshift: begin
            RegDst   = 2'b01;
            MemtoReg = 2'b01;
          end
          default: ;
        endcase
      end
      default: ;
    endcase
    // Reset aborts the instruction: no strobe may escape in the reset cycle.
    if (!reset) begin
      PCWrite     = 1'b0;
      PCWriteCond = 1'b0;
      Branch      = 3'b000;
      IorD        = 1'b0;
      MemRead     = 1'b0;
      MemWrite    = 1'b0;
      IRWrite     = 1'b0;
      MemtoReg    = 2'b00;
      RegDst      = 2'b00;
      RegWrite    = 1'b0;
      ExtOp       = 1'b0;
      LuiOp       = 1'b0;
      ALUSrcA     = 2'b00;
      ALUSrcB     = 2'b00;
      ALUOp       = 4'b0000;
      PCSource    = 2'b00;
    end
  end

  assign bus_err = bus_err_q & reset;
  assign state_o = state_q;

`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  assign illegal_o = reset && (state_q == StExec) && (cls == ClsIllegal);
`endif

endmodule

// File: tb/tb_multicycle_controller.sv
// Randomised scoreboard bench for multicycle_controller. A stimulus process
// walks instructions through their expected cycle sequence and queues the
// expected output vector for every cycle; a monitor compares on the falling edge.
module tb_multicycle_controller;

  localparam int unsigned Timeout = 15;

  localparam int KR = 0, KSH = 1, KI = 2, KLW = 3, KSW = 4, KBR = 5;
  localparam int KJ = 6, KJAL = 7, KJR = 8, KJALR = 9, KILL = 10;
  localparam int NInstr = 26;

  typedef struct packed {
    logic       pcwrite;
    logic       pcwritecond;
    logic [2:0] branch;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic [1:0] memtoreg;
    logic [1:0] regdst;
    logic       regwrite;
    logic       extop;
    logic       luiop;
    logic [1:0] alusrca;
    logic [1:0] alusrcb;
    logic [3:0] aluop;
    logic [1:0] pcsource;
    logic       bus_err;
    logic [2:0] state;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] OpCode, Funct;
  logic       mem_ready;
  logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
  logic [2:0] Branch;
  logic [1:0] MemtoReg, RegDst, ALUSrcA, ALUSrcB, PCSource;
  logic       RegWrite, ExtOp, LuiOp, bus_err;
  logic [3:0] ALUOp;
  logic [2:0] state_o;
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
  logic       illegal_o;
`endif

  int errors = 0;
  int checks = 0;
  exp_t  exp_q[$];
  string tag_q[$];

  multicycle_controller #(.MEM_TIMEOUT(Timeout), .TCNT_W(4)) dut (
    .clk(clk), .reset(reset), .OpCode(OpCode), .Funct(Funct), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .Branch(Branch), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .MemtoReg(MemtoReg),
    .RegDst(RegDst), .RegWrite(RegWrite), .ExtOp(ExtOp), .LuiOp(LuiOp),
    .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .PCSource(PCSource),
    .bus_err(bus_err), .state_o(state_o)
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
    , .illegal_o(illegal_o)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitor: one expected vector per cycle, compared mid-cycle.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t  e, got;
      string t;
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      got = '{PCWrite, PCWriteCond, Branch, IorD, MemRead, MemWrite, IRWrite, MemtoReg,
              RegDst, RegWrite, ExtOp, LuiOp, ALUSrcA, ALUSrcB, ALUOp, PCSource,
              bus_err, state_o};
      checks++;
      if (got !== e) begin
        errors++;
        $display("FAIL %s @%0t: got %h required %h", t, $time, got, e);
      end
    end
  end

  // Instruction table: opcode, funct (R-type only) and class.
  function automatic void get_instr(input int idx, output logic [5:0] op,
                                    output logic [5:0] fn, output int kind);
    fn = 6'h00;
    case (idx)
      0:  begin op = 6'h00; fn = 6'h20; kind = KR;    end // add
      1:  begin op = 6'h00; fn = 6'h23; kind = KR;    end // subu
      2:  begin op = 6'h00; fn = 6'h2a; kind = KR;    end // slt
      3:  begin op = 6'h00; fn = 6'h27; kind = KR;    end // nor
      4:  begin op = 6'h00; fn = 6'h00; kind = KSH;   end // sll
      5:  begin op = 6'h00; fn = 6'h03; kind = KSH;   end // sra
      6:  begin op = 6'h08; kind = KI;                end // addi
      7:  begin op = 6'h0c; kind = KI;                end // andi
      8:  begin op = 6'h0a; kind = KI;                end // slti
      9:  begin op = 6'h0b; kind = KI;                end // sltiu
      10: begin op = 6'h0f; kind = KI;                end // lui
      11: begin op = 6'h23; kind = KLW;               end // lw
      12: begin op = 6'h2b; kind = KSW;               end // sw
      13: begin op = 6'h04; kind = KBR;               end // beq
      14: begin op = 6'h05; kind = KBR;               end // bne
      15: begin op = 6'h06; kind = KBR;               end // blez
      16: begin op = 6'h07; kind = KBR;               end // bgtz
      17: begin op = 6'h01; kind = KBR;               end // bltz
      18: begin op = 6'h02; kind = KJ;                end // j
      19: begin op = 6'h03; kind = KJAL;              end // jal
      20: begin op = 6'h00; fn = 6'h08; kind = KJR;   end // jr
      21: begin op = 6'h00; fn = 6'h09; kind = KJALR; end // jalr
      22: begin op = 6'h3f; kind = KILL;              end // unknown opcode
      23: begin op = 6'h00; fn = 6'h3f; kind = KILL;  end // unknown funct
      24: begin op = 6'h09; kind = KI;                end // addiu
      default: begin op = 6'h00; fn = 6'h02; kind = KSH; end // srl
    endcase
  endfunction

  function automatic exp_t fetch_exp(input logic rdy);
    exp_t e = '0;
    e.memread = 1'b1; e.alusrcb = 2'b01; e.irwrite = rdy; e.pcwrite = rdy;
    e.state = 3'd0;
    return e;
  endfunction

  function automatic exp_t decode_exp();
    exp_t e = '0;
    e.alusrcb = 2'b11; e.extop = 1'b1; e.state = 3'd1;
    return e;
  endfunction

  function automatic exp_t exec_exp(input int kind, input logic [5:0] op);
    exp_t e = '0;
    e.state = 3'd2;
    e.aluop[3] = op[0];
    if (op == 6'h00)                     e.aluop[2:0] = 3'b010;
    else if (kind == KBR)                e.aluop[2:0] = 3'b001;
    else if (op == 6'h0c)                e.aluop[2:0] = 3'b100;
    else if (op == 6'h0a || op == 6'h0b) e.aluop[2:0] = 3'b101;
    case (kind)
      KR:  e.alusrca = 2'b01;
      KSH: e.alusrca = 2'b10;
      KI: begin
        e.alusrca = 2'b01; e.alusrcb = 2'b10; e.extop = 1'b1; e.luiop = (op == 6'h0f);
      end
      KLW, KSW: begin e.alusrca = 2'b01; e.alusrcb = 2'b10; e.extop = 1'b1; end
      KBR: begin
        e.alusrca = 2'b01; e.branch = op[2:0]; e.pcwritecond = 1'b1; e.pcsource = 2'b01;
      end
      KJ:   begin e.pcwrite = 1'b1; e.pcsource = 2'b10; end
      KJAL: begin
        e.pcwrite = 1'b1; e.pcsource = 2'b10;
        e.regwrite = 1'b1; e.regdst = 2'b10; e.memtoreg = 2'b10;
      end
      KJR:  begin e.pcwrite = 1'b1; e.pcsource = 2'b11; end
      KJALR: begin
        e.pcwrite = 1'b1; e.pcsource = 2'b11;
        e.regwrite = 1'b1; e.regdst = 2'b01; e.memtoreg = 2'b10;
      end
      default: ;
    endcase
    return e;
  endfunction

  function automatic exp_t mem_exp(input int kind);
    exp_t e = '0;
    e.iord = 1'b1; e.memread = (kind == KLW); e.memwrite = (kind == KSW); e.state = 3'd3;
    return e;
  endfunction

  function automatic exp_t wb_exp(input int kind);
    exp_t e = '0;
    e.regwrite = 1'b1; e.state = 3'd4;
    if (kind == KI)              e.memtoreg = 2'b01;
    if (kind == KR || kind == KSH) begin e.regdst = 2'b01; e.memtoreg = 2'b01; end
    return e;
  endfunction

  function automatic exp_t halt_exp();
    exp_t e = '0;
    e.bus_err = 1'b1; e.state = 3'd5;
    return e;
  endfunction

  // During reset every control output and bus_err read 0; state_o still shows the old state.
  function automatic exp_t reset_exp(input logic [2:0] st);
    exp_t e = '0;
    e.state = st;
    return e;
  endfunction

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic rdy,
                      input logic rst, input exp_t e, input string tag);
    OpCode = op; Funct = fn; mem_ready = rdy; reset = rst;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(posedge clk);
    #1;
  endtask

  // mode 0: normal, 1: reset during MEM after mw waits, 2: MEM never ready.
  task automatic run_instr(input int idx, input int fw, input int mw, input int mode);
    logic [5:0] op, fn;
    int kind;
    get_instr(idx, op, fn, kind);
    if (op != 6'h00) fn = 6'($urandom);
    for (int i = 0; i < fw; i++) step(op, fn, 1'b0, 1'b1, fetch_exp(1'b0), "fetch_wait");
    step(op, fn, 1'b1, 1'b1, fetch_exp(1'b1), "fetch");
    step(op, fn, rb(), 1'b1, decode_exp(), "decode");
    step(op, fn, rb(), 1'b1, exec_exp(kind, op), "exec");
    if (kind == KLW || kind == KSW) begin
      if (mode == 2) begin
        for (int i = 0; i < Timeout; i++) step(op, fn, 1'b0, 1'b1, mem_exp(kind), "mem_wait");
        for (int i = 0; i < 3; i++) step(op, fn, rb(), 1'b1, halt_exp(), "halt");
        step(op, fn, rb(), 1'b0, reset_exp(3'd5), "halt_reset");
        return;
      end
      for (int i = 0; i < mw; i++) step(op, fn, 1'b0, 1'b1, mem_exp(kind), "mem_wait");
      if (mode == 1) begin
        step(op, fn, rb(), 1'b0, reset_exp(3'd3), "mem_reset");
        return;
      end
      step(op, fn, 1'b1, 1'b1, mem_exp(kind), "mem");
    end
    if (kind == KR || kind == KSH || kind == KI || kind == KLW)
      step(op, fn, rb(), 1'b1, wb_exp(kind), "wb");
  endtask

  task automatic fetch_timeout();
    for (int i = 0; i < Timeout; i++) step(6'h00, 6'h20, 1'b0, 1'b1, fetch_exp(1'b0), "to_wait");
    for (int i = 0; i < 4; i++) step(6'h00, 6'h20, rb(), 1'b1, halt_exp(), "to_halt");
    step(6'h00, 6'h20, 1'b1, 1'b0, reset_exp(3'd5), "to_reset");
  endtask

  initial begin
    int idx, fw, mw;
    reset = 1'b0; OpCode = '0; Funct = '0; mem_ready = 1'b0;
    @(posedge clk);
    #1;
    step(6'h00, 6'h00, 1'b1, 1'b0, reset_exp(3'd0), "reset");

    run_instr(0, 0, 0, 0);    // add, 4 cycles
    run_instr(11, 0, 3, 0);   // lw, 3 MEM waits, 8 cycles
    run_instr(13, 0, 0, 0);   // beq
    run_instr(19, 0, 0, 0);   // jal
    run_instr(21, 1, 0, 0);   // jalr
    run_instr(10, 0, 0, 0);   // lui
`ifndef MULTICYCLE_ILLEGAL_TRAP_EN
    run_instr(22, 0, 0, 0);   // unknown opcode -> NOP
    run_instr(23, 0, 0, 0);   // unknown funct -> NOP
`endif
    run_instr(11, 14, 14, 0); // ready arrives on the last allowed wait cycle
    fetch_timeout();
    run_instr(12, 0, 2, 1);   // reset during sw MEM
    run_instr(0, 0, 0, 0);
    run_instr(11, 0, 0, 2);   // MEM watchdog
    run_instr(12, 2, 1, 0);

    for (int n = 0; n < 80; n++) begin
      logic [5:0] op, fn;
      int kind;
      do begin
        idx = int'($urandom_range(0, NInstr - 1));
        get_instr(idx, op, fn, kind);
`ifdef MULTICYCLE_ILLEGAL_TRAP_EN
      end while (kind == KILL);
`else
      end while (1'b0);
`endif
      fw = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
      mw = ($urandom_range(0, 7) == 0) ? 14 : int'($urandom_range(0, 3));
      run_instr(idx, fw, mw, 0);
    end

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Multi-cycle successor to the single-cycle MIPS main decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB over 3-5+ cycles and drives the shared-ALU, single-memory datapath.
- Stretches FETCH and MEM on a memory ready handshake, with a parametrised wait-timeout watchdog.
- Sits between the IR (OpCode/Funct) and the multi-cycle datapath muxes and enables.

Parameters:
MEM_TIMEOUT, 15, max wait cycles in FETCH/MEM before bus error; 0 disables the watchdog.
TCNT_W, 4, wait-counter width; must satisfy 2^TCNT_W > MEM_TIMEOUT.

Ports:
clk  in  1  clock, rising edge
reset  in  1  synchronous, active-low reset
OpCode  in  6  IR[31:26]; held stable by the datapath after FETCH
Funct  in  6  IR[5:0]
mem_ready  in  1  memory completes the current access this cycle
PCWrite  out  1  unconditional PC load
PCWriteCond  out  1  PC load if the Branch condition holds
Branch  out  3  OpCode[2:0] in branch EXEC, else 0
IorD  out  1  0 = address from PC, 1 = address from ALUOut
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
IRWrite  out  1  IR load
MemtoReg  out  2  00 MDR, 01 ALUOut, 10 PC
RegDst  out  2  00 rt, 01 rd, 10 $31
RegWrite  out  1  register-file write
ExtOp  out  1  1 = sign-extend, 0 = zero-extend
LuiOp  out  1  lui immediate shift
ALUSrcA  out  2  00 PC, 01 rs, 10 shamt
ALUSrcB  out  2  00 rt, 01 const 4, 10 imm, 11 imm<<2
ALUOp  out  4  ALU control class
PCSource  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
bus_err  out  1  sticky; watchdog expired
state_o  out  3  current state, for debug

Behaviour:
- States: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=5.
- reset=0 at a clk edge: state forced to FETCH, wait counter cleared, bus_err cleared.
- While reset=0, every control output is forced to 0.
- Outputs are combinational from state, OpCode and Funct. Outputs not listed for a state are 0.
- FETCH:
  - MemRead=1, IorD=0, ALUSrcA=00, ALUSrcB=01, ALUOp=0000.
  - IRWrite=PCWrite=mem_ready.
  - Stays in FETCH while mem_ready=0; goes to DECODE on mem_ready=1.
- DECODE: ALUSrcA=00, ALUSrcB=11, ExtOp=1, ALUOp=0000 (branch target into ALUOut). Always goes to EXEC.
- EXEC, by instruction class:
  - ALUOp[3]=OpCode[0].
  - ALUOp[2:0]: R-type 010; any branch 001; andi 100; slti/sltiu 101; else 000.
  - R-type ALU op: ALUSrcA=01, or 10 for sll/srl/sra; ALUSrcB=00 → WB.
  - I-type ALU op (addi, addiu, andi, slti, sltiu, lui): ALUSrcA=01, ALUSrcB=10, ExtOp=1, LuiOp=1 for lui only → WB.
  - lw/sw: ALUSrcA=01, ALUSrcB=10, ExtOp=1 → MEM.
  - beq/bne/blez/bgtz/bltz: ALUSrcA=01, ALUSrcB=00, Branch=OpCode[2:0], PCWriteCond=1, PCSource=01 → FETCH.
  - j: PCWrite=1, PCSource=10 → FETCH.
  - jal: same as j, plus RegWrite=1, RegDst=10, MemtoReg=10 → FETCH.
  - jr: PCWrite=1, PCSource=11 → FETCH.
  - jalr: same as jr, plus RegWrite=1, RegDst=01, MemtoReg=10 → FETCH.
  - Unknown opcode/funct: no strobes → FETCH (NOP).
- MEM:
  - IorD=1; MemRead=1 for lw, MemWrite=1 for sw. Strobes stay asserted for the whole wait.
  - Stays in MEM while mem_ready=0.
  - On mem_ready=1: lw → WB, sw → FETCH.
- WB: RegWrite=1, then → FETCH.
  - lw: RegDst=00, MemtoReg=00.
  - I-type: RegDst=00, MemtoReg=01.
  - R-type: RegDst=01, MemtoReg=01.
- Wait counter:
  - Increments each cycle spent in FETCH or MEM with mem_ready=0.
  - Clears on any state change.
  - Saturates; never wraps.
- Watchdog: MEM_TIMEOUT≠0 and the counter reaches MEM_TIMEOUT with mem_ready still 0 → next state HALT, bus_err=1.
- mem_ready=1 in the same cycle the counter reaches the limit: the access completes, no error.
- HALT: all strobes 0; held until reset.
- mem_ready outside FETCH/MEM is ignored.
- Reset asserted mid-instruction aborts it; no write strobe is issued in the reset cycle.

Optional Feature:
- Macro: MULTICYCLE_ILLEGAL_TRAP_EN.
- Defined:
  - Unknown opcode/funct in EXEC pulses output illegal_o=1 for exactly one cycle.
  - Next state is HALT; bus_err is unaffected.
- Undefined: the illegal_o port is absent; unknown instructions execute as a 3-cycle NOP.

Test Plan:
- add, mem_ready tied 1 → FETCH,DECODE,EXEC,WB in 4 cycles; WB has RegWrite=1, RegDst=01, MemtoReg=01; EXEC has ALUOp=0010.
- lw with mem_ready low 3 cycles in MEM → MEM held 4 cycles with MemRead=1, IorD=1; then WB with MemtoReg=00; total 8 cycles.
- beq (OpCode=04) → EXEC has Branch=100, PCWriteCond=1, PCSource=01, ALUOp=0001; returns to FETCH after 3 cycles.
- jal → EXEC has PCWrite=1, PCSource=10, RegWrite=1, RegDst=10, MemtoReg=10.
- MEM_TIMEOUT=15, mem_ready held 0 in FETCH → HALT entered after 15 wait cycles; bus_err=1 and stays 1 until reset=0.
- Assert reset=0 during MEM of sw → MemWrite=0 that cycle; state_o=0 on the next edge.
